// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and helpers for the fetch-stage PC generator
// Contents: FSM state encoding, redirect-kind encoding, alignment-mask helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    JUMP = 2'd1,
    TRAP = 2'd2
  } redir_kind_t;

  // Low address bits that must be zero for an aligned target.
  function automatic logic [1:0] align_mask(input logic half);
    return half ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - pending-redirect register with trap-over-jump rule
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr               a redirect wants to be parked
//   clr              the parked redirect is being consumed this cycle
//   kind, addr       kind and aligned target of the incoming redirect
//   taken            the incoming redirect is accepted into the register
//   pend_valid       a redirect is parked
//   pend_addr        aligned target of the parked redirect
import pc_gen_pkg::*;

module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              clr,
  input  logic [1:0]        kind,
  input  logic [ADDR_W-1:0] addr,
  output logic              taken,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr
);

  logic              valid_q;
  redir_kind_t       kind_q;
  logic [ADDR_W-1:0] addr_q;
  logic              blocked;

  // A parked trap survives a later jump, unless the trap is being consumed
  // in this very cycle, in which case the slot is free for the jump.
  assign blocked = valid_q && (kind_q == TRAP) && (kind == JUMP) && !clr;
  assign taken   = wr && !blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      kind_q  <= NONE;
      addr_q  <= '0;
    end else if (taken) begin
      valid_q <= 1'b1;
      kind_q  <= redir_kind_t'(kind);
      addr_q  <= addr;
    end else if (clr) begin
      valid_q <= 1'b0;
      kind_q  <= NONE;
    end
  end

  assign pend_valid = valid_q;
  assign pend_addr  = addr_q;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with valid/ready requests
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   stall_i, halt_i         downstream full / level halt request
//   jump_i, jump_addr_i     jump redirect strobe and target
//   trap_i, trap_addr_i     trap redirect strobe and vector (beats jump)
//   req_valid_o, req_addr_o fetch request towards instruction memory
//   req_ready_i             instruction memory accepts the request
//   ce_o                    chip enable, high in RUN and HALT
//   misalign_o              pulse: a misaligned redirect target was taken
//   misalign_addr_o         raw target of the last misaligned redirect
import pc_gen_pkg::*;

module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                STEP       = 4,
  parameter int                HALF_ALIGN = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  output logic              ce_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  localparam logic [1:0]        LOW_MASK = align_mask(HALF_ALIGN != 0);
  localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              hold_q;
  logic              ce_q;
  logic              mis_q;
  logic [ADDR_W-1:0] mis_addr_q;

  logic              redir;
  redir_kind_t       kind;
  logic [ADDR_W-1:0] raw;
  logic [ADDR_W-1:0] tgt;
  logic              mis;
  logic              valid;
  logic              accept;
  logic              outstanding;
  logic              buf_wr;
  logic              buf_clr;
  logic              buf_taken;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              sel_taken;
  logic [ADDR_W-1:0] pc_next;

  assign redir = trap_i | jump_i;
  assign kind  = trap_i ? TRAP : (jump_i ? JUMP : NONE);
  assign raw   = trap_i ? trap_addr_i : jump_addr_i;
  assign tgt   = {raw[ADDR_W-1:2], raw[1:0] & ~LOW_MASK};
  assign mis   = |(raw[1:0] & LOW_MASK);

  // hold_q can only be set in RUN and RUN is never left while it is set,
  // so a raised request stays up until accepted.
  assign valid       = (state_q == RUN) && (hold_q || !stall_i);
  assign accept      = valid && req_ready_i;
  assign outstanding = valid && !req_ready_i;

  // Park the redirect while a request waits, and also when an accept is
  // consuming an earlier parked redirect so the new one is not lost.
  assign buf_wr  = redir && (outstanding || (accept && pend_valid));
  assign buf_clr = accept && pend_valid;

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk        (clk_i),
    .rst        (rst_i),
    .wr         (buf_wr),
    .clr        (buf_clr),
    .kind       (kind),
    .addr       (tgt),
    .taken      (buf_taken),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr)
  );

  // A jump refused by a parked trap is not a taken redirect.
  assign sel_taken = buf_wr ? buf_taken : redir;

  always_comb begin
    pc_next = pc_q;
    if (accept) begin
      if (pend_valid)  pc_next = pend_addr;
      else if (redir)  pc_next = tgt;
      else             pc_next = pc_q + STEP_W;
    end else if (redir && !outstanding) begin
      pc_next = tgt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      hold_q     <= 1'b0;
      ce_q       <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      pc_q   <= pc_next;
      hold_q <= outstanding;
      mis_q  <= sel_taken && mis;
      if (sel_taken && mis) mis_addr_q <= raw;
      case (state_q)
        IDLE: begin
          state_q <= RUN;
          ce_q    <= 1'b1;
        end
        RUN:  if (halt_i && !outstanding) state_q <= HALT;
        HALT: if (!halt_i) state_q <= RUN;
        default: begin
          state_q <= IDLE;
          ce_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid_o     = valid;
  assign req_addr_o      = pc_q;
  assign ce_o            = ce_q;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;

endmodule
